// File: rtl/stack_seq_pkg.sv
// Shared opcode/state encodings for the stack op sequencer.
// Pure declarations: no latency, no flow control.
// Backpressure: not applicable.
package stack_seq_pkg;

    localparam int WIDTH_DEFAULT = 32;

    typedef enum logic [2:0] {
        OP_PUSHI = 3'd0,
        OP_POP   = 3'd1,
        OP_ADD   = 3'd2,
        OP_SUB   = 3'd3,
        OP_AND   = 3'd4,
        OP_OR    = 3'd5,
        OP_SLT   = 3'd6,
        OP_MUL   = 3'd7
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LATCH = 3'd1,
        ST_POP1  = 3'd2,
        ST_POP2  = 3'd3,
        ST_PUSH  = 3'd4
    } state_e;

    function automatic logic is_alu(input op_e op);
        return (op != OP_PUSHI) && (op != OP_POP);
    endfunction

endpackage

// File: rtl/stack_seq_alu.sv
// Combinational binary ALU for the stack op sequencer; MUL exists only with STACK_OP_MUL_EN.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; result follows inputs.
module stack_seq_alu
    import stack_seq_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  op_e              op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result
);

    always_comb begin
        result = '0;
        case (op)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
`ifdef STACK_OP_MUL_EN
            OP_MUL:  result = a * b;
`endif
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/stack_op_sequencer.sv
// Command-driven STACK initiator: PUSHI/POP/binary ALU ops, local occupancy tracking (MUL via STACK_OP_MUL_EN).
// Latency: PUSHI 1 cycle, POP 2 cycles, ALU 4 cycles from accept to res_valid; rejects pulse err after 1 cycle.
// Backpressure: cmd_ready is high only in IDLE; cmd_valid while busy is ignored.
module stack_op_sequencer
    import stack_seq_pkg::*;
#(
    parameter  int WIDTH = WIDTH_DEFAULT,
    parameter  int DEPTH = 8,
    localparam int DW    = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_imm,
    output logic             stk_push,
    output logic             stk_pop,
    output logic [WIDTH-1:0] stk_data,
    input  logic [WIDTH-1:0] stk_top,
    input  logic [WIDTH-1:0] stk_next,
    output logic             res_valid,
    output logic [WIDTH-1:0] res_data,
    output logic             err,
    output logic [DW-1:0]    depth
);

    localparam logic [DW-1:0] DEPTH_MAX = DW'(DEPTH);

    state_e           state_q, state_d;
    op_e              op_q;
    op_e              cmd_op_e;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] alu_res;
    logic [DW-1:0]    depth_q;
    logic             err_q;
    logic             accept;
    logic             reject;
    logic             op_illegal;

    assign cmd_op_e = op_e'(cmd_op);
    assign accept   = cmd_valid && (state_q == ST_IDLE);

`ifdef STACK_OP_MUL_EN
    assign op_illegal = 1'b0;
`else
    assign op_illegal = (cmd_op_e == OP_MUL);
`endif

    // Checks in priority order; a reject leaves the stack and depth untouched.
    always_comb begin
        reject = 1'b0;
        if (op_illegal)
            reject = 1'b1;
        else if (cmd_op_e == OP_PUSHI)
            reject = (depth_q == DEPTH_MAX);
        else if (cmd_op_e == OP_POP)
            reject = (depth_q == '0);
        else
            reject = (depth_q == '0) || (depth_q == DW'(1));
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept && !reject)
                          state_d = (cmd_op_e == OP_PUSHI) ? ST_PUSH : ST_LATCH;
            ST_LATCH: state_d = ST_POP1;
            ST_POP1:  state_d = is_alu(op_q) ? ST_POP2 : ST_IDLE;
            ST_POP2:  state_d = ST_PUSH;
            ST_PUSH:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    stack_seq_alu #(.WIDTH(WIDTH)) u_alu (
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .result (alu_res)
    );

    // res_q doubles as the push payload, so res_data and stk_data agree on push cycles.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            op_q    <= OP_PUSHI;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            depth_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= accept && reject;
            if (accept && !reject) begin
                op_q <= cmd_op_e;
                if (cmd_op_e == OP_PUSHI)
                    res_q <= cmd_imm;
            end
            if (state_q == ST_LATCH) begin
                a_q <= stk_next;
                b_q <= stk_top;
                if (op_q == OP_POP)
                    res_q <= stk_top;
            end
            if (state_q == ST_POP2)
                res_q <= alu_res;
            if (state_q == ST_PUSH)
                depth_q <= depth_q + DW'(1);
            else if ((state_q == ST_POP1) || (state_q == ST_POP2))
                depth_q <= depth_q - DW'(1);
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign stk_push  = (state_q == ST_PUSH);
    assign stk_pop   = (state_q == ST_POP1) || (state_q == ST_POP2);
    assign stk_data  = stk_push ? res_q : '0;
    assign res_valid = (state_q == ST_PUSH) || ((state_q == ST_POP1) && (op_q == OP_POP));
    assign res_data  = res_q;
    assign err       = err_q;
    assign depth     = depth_q;

endmodule
